// File: rtl/fetch_unit_pkg.sv
// Shared widths, the prefetch entry layout and byte/word address helpers
// for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int WORD_W  = 32;
  localparam int WADDR_W = 30;
  localparam int ENTRY_W = WORD_W + WADDR_W;

  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic [WADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WADDR_W-1:0] byte_to_word(input logic [WORD_W-1:0] baddr);
    return baddr[WORD_W-1:2];
  endfunction

  function automatic logic [WORD_W-1:0] word_to_byte(input logic [WADDR_W-1:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. The head entry is held in its own register, so
// a word pushed this cycle is visible at the output next cycle at the earliest.
module fetch_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         out_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [WIDTH-1:0] head_r, head_nxt_s;
  logic             push_en_s, pop_en_s;

  // Next pointers, occupancy and head entry; flush overrides push and pop.
  always_comb begin
    pop_en_s     = pop & (count_r != {CW{1'b0}}) & ~flush;
    push_en_s    = push & ~flush & ((count_r != FULL_CNT) | pop_en_s);
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = {WIDTH{1'b0}};
    if (flush) begin
      rd_ptr_nxt_s = {PW{1'b0}};
      wr_ptr_nxt_s = {PW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(pop_en_s);
      wr_ptr_nxt_s = wr_ptr_r + PW'(push_en_s);
      count_nxt_s  = count_r + CW'(push_en_s) - CW'(pop_en_s);
      // The new head is the word being pushed only when nothing older remains.
      if (count_nxt_s == {CW{1'b0}}) begin
        head_nxt_s = {WIDTH{1'b0}};
      end else if (push_en_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
        head_nxt_s = push_data;
      end else begin
        head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign empty    = (count_r == {CW{1'b0}});
  assign full     = (count_r == FULL_CNT);
  assign count    = count_r;
  assign out_data = head_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: read-only master on memory port A, prefetch FIFO
// toward decode, and redirect handling that discards every older word.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WADDR_W-1:0]   mem_addr,
  output logic                 mem_wr,
  output logic [WORD_W-1:0]    mem_datain,
  input  logic [WORD_W-1:0]    mem_dataout,
  input  logic                 redirect,
  input  logic [WORD_W-1:0]    redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_W-1:0]    inst_data,
  output logic [WORD_W-1:0]    inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [WADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [WADDR_W-1:0] inflight_pc_r, inflight_pc_nxt_s;
  logic               inflight_r, inflight_nxt_s;
  logic [CW-1:0]      fifo_count_s;
  logic               fifo_empty_s, fifo_full_s;
  logic [CW:0]        occupancy_s;
  logic               pop_s, issue_s;
  fetch_entry_t       push_entry_s, head_entry_s;

  assign pop_s       = inst_valid & inst_ready;
  // Words buffered plus the one in flight, after this cycle's pop.
  assign occupancy_s = {1'b0, fifo_count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
  assign issue_s     = ~redirect & ~(fifo_full_s & ~pop_s) & (occupancy_s < OCC_LIMIT);

  // Fetch PC and in-flight tracking; redirect wins over issue.
  always_comb begin
    fetch_pc_nxt_s    = fetch_pc_r;
    inflight_nxt_s    = 1'b0;
    inflight_pc_nxt_s = inflight_pc_r;
    if (redirect) begin
      fetch_pc_nxt_s = byte_to_word(redirect_pc);
    end else if (issue_s) begin
      fetch_pc_nxt_s    = fetch_pc_r + 30'd1;
      inflight_nxt_s    = 1'b1;
      inflight_pc_nxt_s = fetch_pc_r;
    end else begin
      inflight_nxt_s = 1'b0;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= byte_to_word(RESET_PC);
      inflight_r    <= 1'b0;
      inflight_pc_r <= {WADDR_W{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      inflight_r    <= inflight_nxt_s;
      inflight_pc_r <= inflight_pc_nxt_s;
    end
  end

  assign push_entry_s = '{data: mem_dataout, pc: inflight_pc_r};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s),
    .out_data  (head_entry_s)
  );

  assign mem_addr   = fetch_pc_r;
  assign mem_wr     = 1'b0;
  assign mem_datain = {WORD_W{1'b0}};
  assign inst_valid = ~fifo_empty_s;
  assign inst_data  = head_entry_s.data;
  assign inst_pc    = word_to_byte(head_entry_s.pc);

endmodule
